// File: rtl/biriscv_divider_radix.sv
// Radix-2^BITS_PER_CYCLE restoring divider for DIV/DIVU/REM/REMU.
// Optional last-result cache: define DIVIDER_RESULT_CACHE_EN.
module biriscv_divider_radix #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_CNT = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic             rem_sel_q;
  logic [WIDTH-1:0] result_q;

  assign ready_o  = (state_q != ST_CALC);
  assign busy_o   = (state_q == ST_CALC);
  assign valid_o  = (state_q == ST_DONE);
  assign result_o = result_q;

  // Operand decode at acceptance
  logic             signed_op;
  logic             is_rem;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic             ovf;
  logic [WIDTH-1:0] special_res;
  logic             accept;

  always_comb begin
    signed_op   = ~op_i[0];
    is_rem      = op_i[1];
    a_neg       = signed_op & a_i[WIDTH-1];
    b_neg       = signed_op & b_i[WIDTH-1];
    a_mag       = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag       = b_neg ? (~b_i + 1'b1) : b_i;
    b_zero      = (b_i == '0);
    ovf         = signed_op & (a_i == MOST_NEG) & (b_i == '1);
    special_res = '0;
    if (b_zero)
      special_res = is_rem ? a_i : '1;
    else
      special_res = is_rem ? '0 : MOST_NEG;
    accept      = start_i & ready_o & ~flush_i;
  end

  // BITS_PER_CYCLE restoring steps per cycle, MSB of the dividend first
  logic [WIDTH-1:0] quot_n;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH:0]   rem_ext;
  logic [WIDTH-1:0] res_calc;

  always_comb begin
    quot_n  = quot_q;
    rem_n   = rem_q;
    rem_ext = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_ext = {rem_n, quot_n[WIDTH-1]};
      quot_n  = {quot_n[WIDTH-2:0], 1'b0};
      if (rem_ext >= {1'b0, div_q}) begin
        rem_ext   = rem_ext - {1'b0, div_q};
        quot_n[0] = 1'b1;
      end
      rem_n = rem_ext[WIDTH-1:0];
    end
    if (rem_sel_q)
      res_calc = neg_rem_q ? (~rem_n + 1'b1) : rem_n;
    else
      res_calc = neg_quot_q ? (~quot_n + 1'b1) : quot_n;
  end

`ifdef DIVIDER_RESULT_CACHE_EN
  logic             cache_valid_q;
  logic [WIDTH-1:0] cache_a_q;
  logic [WIDTH-1:0] cache_b_q;
  logic [1:0]       cache_op_q;
  logic [WIDTH-1:0] cache_res_q;
  logic [WIDTH-1:0] req_a_q;
  logic [WIDTH-1:0] req_b_q;
  logic [1:0]       req_op_q;
  logic             cache_hit;
  logic [WIDTH-1:0] cache_hit_res;

  // The op completing this cycle is not in the cache yet; match it directly
  always_comb begin
    cache_hit     = 1'b0;
    cache_hit_res = cache_res_q;
    if (valid_o && req_a_q == a_i && req_b_q == b_i && req_op_q == op_i) begin
      cache_hit     = 1'b1;
      cache_hit_res = result_q;
    end else if (cache_valid_q && cache_a_q == a_i && cache_b_q == b_i &&
                 cache_op_q == op_i) begin
      cache_hit     = 1'b1;
      cache_hit_res = cache_res_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cache_valid_q <= 1'b0;
      cache_a_q     <= '0;
      cache_b_q     <= '0;
      cache_op_q    <= '0;
      cache_res_q   <= '0;
      req_a_q       <= '0;
      req_b_q       <= '0;
      req_op_q      <= '0;
    end else begin
      if (accept) begin
        req_a_q  <= a_i;
        req_b_q  <= b_i;
        req_op_q <= op_i;
      end
      if (valid_o) begin
        cache_valid_q <= 1'b1;
        cache_a_q     <= req_a_q;
        cache_b_q     <= req_b_q;
        cache_op_q    <= req_op_q;
        cache_res_q   <= result_q;
      end
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      rem_sel_q  <= 1'b0;
      result_q   <= '0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_CALC: begin
          quot_q <= quot_n;
          rem_q  <= rem_n;
          if (count_q == '0) begin
            result_q <= res_calc;
            state_q  <= ST_DONE;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        default: begin
          if (accept) begin
            if (b_zero || ovf) begin
              result_q <= special_res;
              state_q  <= ST_DONE;
            end
`ifdef DIVIDER_RESULT_CACHE_EN
            else if (cache_hit) begin
              result_q <= cache_hit_res;
              state_q  <= ST_DONE;
            end
`endif
            else begin
              quot_q     <= a_mag;
              rem_q      <= '0;
              div_q      <= b_mag;
              neg_quot_q <= a_neg ^ b_neg;
              neg_rem_q  <= a_neg;
              rem_sel_q  <= is_rem;
              count_q    <= LAST_CNT;
              state_q    <= ST_CALC;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_biriscv_divider_radix.sv
// Directed bench for biriscv_divider_radix (WIDTH=32, BITS_PER_CYCLE=2).
module tb_biriscv_divider_radix;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush_i = 1'b0;
  logic        ready_o;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  biriscv_divider_radix #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Drives one request and waits for valid_o; lat = 1 means valid right after acceptance edge
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int vcyc);
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    if (!valid_o) lat = -1;
    res  = result_o;
    vcyc = cyc;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_o); end
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid_o); end
    tests++; if (result_o !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", result_o); end
    @(negedge clk_i); rst_i = 1'b0;
  endtask

  task automatic test_signed();
    logic [31:0] r; int lat; int vc;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, r, lat, vc);
    tests++; if (r !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_m7_2 got %h want FFFFFFFD", r); end
    tests++; if (lat !== 17) begin fails++; $display("FAIL div_m7_2_lat got %0d want 17", lat); end
    run_op(OP_REM, 32'hFFFFFFF9, 32'd2, r, lat, vc);
    tests++; if (r !== 32'hFFFFFFFF) begin fails++; $display("FAIL rem_m7_2 got %h want FFFFFFFF", r); end
    tests++; if (lat !== 17) begin fails++; $display("FAIL rem_m7_2_lat got %0d want 17", lat); end
    run_op(OP_DIV, 32'd20, 32'hFFFFFFFA, r, lat, vc);
    tests++; if (r !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_20_m6 got %h want FFFFFFFD", r); end
    run_op(OP_REM, 32'd20, 32'hFFFFFFFA, r, lat, vc);
    tests++; if (r !== 32'd2) begin fails++; $display("FAIL rem_20_m6 got %h want 2", r); end
    run_op(OP_DIVU, 32'hFFFFFFF9, 32'd2, r, lat, vc);
    tests++; if (r !== 32'h7FFFFFFC) begin fails++; $display("FAIL divu_big_2 got %h want 7FFFFFFC", r); end
  endtask

  task automatic test_div_zero();
    logic [31:0] r; int lat; int vc;
    run_op(OP_DIVU, 32'd5, 32'd0, r, lat, vc);
    tests++; if (r !== 32'hFFFFFFFF) begin fails++; $display("FAIL divu_5_0 got %h want FFFFFFFF", r); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL divu_5_0_lat got %0d want 1", lat); end
    run_op(OP_REMU, 32'd5, 32'd0, r, lat, vc);
    tests++; if (r !== 32'd5) begin fails++; $display("FAIL remu_5_0 got %h want 5", r); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL remu_5_0_lat got %0d want 1", lat); end
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd0, r, lat, vc);
    tests++; if (r !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_m7_0 got %h want FFFFFFFF", r); end
    @(posedge clk_i); #1;
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL valid_one_cycle got %b want 0", valid_o); end
  endtask

  task automatic test_overflow();
    logic [31:0] r; int lat; int vc;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, r, lat, vc);
    tests++; if (r !== 32'h80000000) begin fails++; $display("FAIL div_ovf got %h want 80000000", r); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL div_ovf_lat got %0d want 1", lat); end
    run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, r, lat, vc);
    tests++; if (r !== 32'h0) begin fails++; $display("FAIL rem_ovf got %h want 0", r); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL rem_ovf_lat got %0d want 1", lat); end
    run_op(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, r, lat, vc);
    tests++; if (r !== 32'h0) begin fails++; $display("FAIL divu_big got %h want 0", r); end
    tests++; if (lat !== 17) begin fails++; $display("FAIL divu_big_lat got %0d want 17", lat); end
  endtask

  task automatic test_flush();
    logic [31:0] r; int lat; int vc; bit seen;
    @(negedge clk_i);
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk_i); #1; start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i); flush_i = 1'b1;
    @(posedge clk_i); #1; flush_i = 1'b0;
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL flush_ready got %b want 1", ready_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL flush_busy got %b want 0", busy_o); end
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (valid_o) seen = 1'b1;
      @(posedge clk_i); #1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL flush_no_valid got %b want 0", seen); end
    // Flush and start together in IDLE: start must be dropped
    @(negedge clk_i);
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_DIVU; a_i = 32'd9; b_i = 32'd0;
    @(posedge clk_i); #1; start_i = 1'b0; flush_i = 1'b0;
    tests++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin fails++;
      $display("FAIL flush_start valid %b busy %b want 0 0", valid_o, busy_o); end
    run_op(OP_DIVU, 32'd100, 32'd7, r, lat, vc);
    tests++; if (r !== 32'd14) begin fails++; $display("FAIL divu_100_7 got %h want 14", r); end
    tests++; if (lat !== 17) begin fails++; $display("FAIL divu_100_7_lat got %0d want 17", lat); end
    run_op(OP_REMU, 32'd100, 32'd7, r, lat, vc);
    tests++; if (r !== 32'd2) begin fails++; $display("FAIL remu_100_7 got %h want 2", r); end
  endtask

  task automatic test_start_in_calc();
    int lat;
    @(negedge clk_i);
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk_i); #1;
    op_i = OP_DIV; a_i = 32'd1; b_i = 32'd1;
    lat = 1;
    while (!valid_o && lat < 100) begin
      if (lat == 6) start_i = 1'b0;
      @(posedge clk_i); #1;
      lat++;
    end
    start_i = 1'b0;
    tests++; if (result_o !== 32'd14) begin fails++; $display("FAIL calc_ignore_start got %h want 14", result_o); end
    tests++; if (lat !== 17) begin fails++; $display("FAIL calc_ignore_lat got %0d want 17", lat); end
    repeat (3) @(posedge clk_i); #1;
    tests++; if (result_o !== 32'd14) begin fails++; $display("FAIL result_hold got %h want 14", result_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1; logic [31:0] r2; int lat; int t1; int t2;
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'd3, r1, lat, t1);
    run_op(OP_REMU, 32'd10, 32'd3, r2, lat, t2);
    tests++; if (r1 !== 32'h55555555) begin fails++; $display("FAIL b2b_divu got %h want 55555555", r1); end
    tests++; if (r2 !== 32'd1) begin fails++; $display("FAIL b2b_remu got %h want 1", r2); end
    tests++; if (t2 - t1 !== 17) begin fails++; $display("FAIL b2b_spacing got %0d want 17", t2 - t1); end
  endtask

  task automatic test_reset_mid_calc();
    bit seen;
    @(negedge clk_i);
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd1000; b_i = 32'd7;
    @(posedge clk_i); #1; start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2; rst_i = 1'b1; #1;
    tests++; if (busy_o !== 1'b0 || ready_o !== 1'b1) begin fails++;
      $display("FAIL async_reset busy %b ready %b want 0 1", busy_o, ready_o); end
    tests++; if (result_o !== 32'h0) begin fails++; $display("FAIL async_reset_result got %h want 0", result_o); end
    @(negedge clk_i); rst_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL reset_no_valid got %b want 0", seen); end
  endtask

  task automatic test_cache();
    logic [31:0] r; int lat; int vc; int exp_lat;
`ifdef DIVIDER_RESULT_CACHE_EN
    exp_lat = 1;
`else
    exp_lat = 17;
`endif
    run_op(OP_DIVU, 32'd1000, 32'd10, r, lat, vc);
    tests++; if (r !== 32'd100) begin fails++; $display("FAIL cache_first got %h want 100", r); end
    tests++; if (lat !== 17) begin fails++; $display("FAIL cache_first_lat got %0d want 17", lat); end
    run_op(OP_DIVU, 32'd1000, 32'd10, r, lat, vc);
    tests++; if (r !== 32'd100) begin fails++; $display("FAIL cache_second got %h want 100", r); end
    tests++; if (lat !== exp_lat) begin fails++; $display("FAIL cache_second_lat got %0d want %0d", lat, exp_lat); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_start_in_calc();
    test_back_to_back();
    test_reset_mid_calc();
    test_cache();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
